// File: rtl/maxpool1_layer.sv
// maxpool1_layer: 2x2 signed max pool of three raster-ordered channels; in: clk, rst_n (active-high sync), conv_out_1..3, valid_out_conv; out: pool_out_1..3, valid_out_pool, frame_done
module maxpool1_layer #(
  parameter int WIDTH = 24,
  parameter int HEIGHT = 24,
  parameter int DATA_BITS = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [DATA_BITS-1:0] conv_out_1,
  input  logic signed [DATA_BITS-1:0] conv_out_2,
  input  logic signed [DATA_BITS-1:0] conv_out_3,
  input  logic                        valid_out_conv,
  output logic signed [DATA_BITS-1:0] pool_out_1,
  output logic signed [DATA_BITS-1:0] pool_out_2,
  output logic signed [DATA_BITS-1:0] pool_out_3,
  output logic                        valid_out_pool,
  output logic                        frame_done
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-2:0] half;
  logic last_col, last_row, pool_beat, lb_write;
  logic signed [DATA_BITS-1:0] din [3];
  logic signed [DATA_BITS-1:0] pair [3];
  logic signed [DATA_BITS-1:0] pool [3];
  logic signed [DATA_BITS-1:0] hmax [3];
  logic signed [DATA_BITS-1:0] pmax [3];
  logic signed [DATA_BITS-1:0] lb [3][WIDTH/2];
  assign din[0] = conv_out_1;
  assign din[1] = conv_out_2;
  assign din[2] = conv_out_3;
  assign pool_out_1 = pool[0];
  assign pool_out_2 = pool[1];
  assign pool_out_3 = pool[2];
  assign half = col[CW-1:1];
  assign last_col = col == CW'(WIDTH - 1);
  assign last_row = row == RW'(HEIGHT - 1);
  assign pool_beat = valid_out_conv && col[0] && row[0];
  assign lb_write = valid_out_conv && col[0] && !row[0];
  always_comb
    for (int k = 0; k < 3; k++) begin
      hmax[k] = pair[k] > din[k] ? pair[k] : din[k];
      pmax[k] = lb[k][half] > hmax[k] ? lb[k][half] : hmax[k];
    end
  always_ff @(posedge clk)
    if (rst_n) begin
      col <= '0;
      row <= '0;
      valid_out_pool <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        pair[k] <= '0;
        pool[k] <= '0;
      end
    end else begin
      valid_out_pool <= pool_beat;
      frame_done <= pool_beat && last_col && last_row;
      if (valid_out_conv) begin
        col <= last_col ? '0 : col + CW'(1);
        if (last_col) row <= last_row ? '0 : row + RW'(1);
      end
      for (int k = 0; k < 3; k++) begin
        if (valid_out_conv && !col[0]) pair[k] <= din[k];
        if (pool_beat) pool[k] <= pmax[k];
      end
    end
  always_ff @(posedge clk)
    if (!rst_n && lb_write)
      for (int k = 0; k < 3; k++) lb[k][half] <= hmax[k];
endmodule

// File: tb/tb_maxpool1_layer.sv
// tb_maxpool1_layer: self-checking bench with per-pixel 2x2 block-max reference model
module tb_maxpool1_layer;
  localparam int W = 24;
  localparam int H = 24;
  localparam int DB = 12;
  typedef struct {int a; int b; int c; int d; int e;} vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic valid_out_conv = 1'b0;
  logic signed [DB-1:0] conv_out_1 = '0, conv_out_2 = '0, conv_out_3 = '0;
  logic signed [DB-1:0] pool_out_1, pool_out_2, pool_out_3;
  logic valid_out_pool, frame_done;
  int checks = 0;
  int errors = 0;
  int img [3][H][W];
  int held [3];
  int npulse, nfd, first1, first2, last1, last_fd;
  vec_t tv [6];
  always #5 clk = ~clk;
  maxpool1_layer #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .conv_out_1(conv_out_1), .conv_out_2(conv_out_2), .conv_out_3(conv_out_3),
    .valid_out_conv(valid_out_conv),
    .pool_out_1(pool_out_1), .pool_out_2(pool_out_2), .pool_out_3(pool_out_3),
    .valid_out_pool(valid_out_pool), .frame_done(frame_done)
  );
  function automatic int mx(int a, int b);
    return a > b ? a : b;
  endfunction
  task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic beat(int r, int c, bit v);
    bit ev, ef;
    @(negedge clk);
    valid_out_conv = v;
    conv_out_1 = v ? DB'(img[0][r][c]) : DB'($urandom);
    conv_out_2 = v ? DB'(img[1][r][c]) : DB'($urandom);
    conv_out_3 = v ? DB'(img[2][r][c]) : DB'($urandom);
    ev = v && (r % 2 == 1) && (c % 2 == 1);
    ef = ev && r == H - 1 && c == W - 1;
    if (ev)
      for (int k = 0; k < 3; k++)
        held[k] = mx(mx(img[k][r-1][c-1], img[k][r-1][c]), mx(img[k][r][c-1], img[k][r][c]));
    @(posedge clk);
    #1;
    chk("valid_out_pool", valid_out_pool, ev);
    chk("frame_done", frame_done, ef);
    chk("pool_out_1", pool_out_1, held[0]);
    chk("pool_out_2", pool_out_2, held[1]);
    chk("pool_out_3", pool_out_3, held[2]);
    if (valid_out_pool) begin
      if (npulse == 0) begin
        first1 = pool_out_1;
        first2 = pool_out_2;
      end
      last1 = pool_out_1;
      last_fd = frame_done;
      npulse++;
      if (frame_done) nfd++;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    valid_out_conv = 1'b1;
    repeat (2) begin
      conv_out_1 = DB'($urandom);
      conv_out_2 = DB'($urandom);
      conv_out_3 = DB'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_valid", valid_out_pool, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pool_1", pool_out_1, 0);
    chk("rst_pool_2", pool_out_2, 0);
    chk("rst_pool_3", pool_out_3, 0);
    held = '{0, 0, 0};
    @(negedge clk);
    rst_n = 1'b0;
    valid_out_conv = 1'b0;
  endtask
  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[0][r][c] = r * W + c;
        img[1][r][c] = -(r * W + c);
        img[2][r][c] = -(r * W + c);
      end
  endtask
  task automatic fill_rand();
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) img[k][r][c] = int'($urandom_range(0, 4095)) - 2048;
  endtask
  task automatic run_frame(bit gap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gap) while ($urandom_range(0, 1) == 1) beat(0, 0, 1'b0);
        beat(r, c, 1'b1);
      end
  endtask
  task automatic check_ramp(string tag);
    chk({tag, "_pulses"}, npulse, 144);
    chk({tag, "_frame_done_count"}, nfd, 1);
    chk({tag, "_first_ch1"}, first1, 25);
    chk({tag, "_first_ch2"}, first2, 0);
    chk({tag, "_last_ch1"}, last1, 575);
    chk({tag, "_last_frame_done"}, last_fd, 1);
  endtask
  initial begin
    tv[0] = '{-5, -3, -7, -1, -1};
    tv[1] = '{7, 7, 7, 7, 7};
    tv[2] = '{-2048, -2048, -2048, -2048, -2048};
    tv[3] = '{2047, -2048, 0, -1, 2047};
    tv[4] = '{-2048, -1, -2048, -2048, -1};
    tv[5] = '{0, 0, 0, -1, 0};
    npulse = 0;
    nfd = 0;
    held = '{0, 0, 0};
    fill_ramp();
    do_reset();
    beat(0, 0, 1'b0);
    beat(0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_reset();
      fill_rand();
      for (int k = 0; k < 3; k++) begin
        img[k][0][0] = tv[i].a;
        img[k][0][1] = tv[i].b;
        img[k][1][0] = tv[i].c;
        img[k][1][1] = tv[i].d;
      end
      for (int c = 0; c < W; c++) beat(0, c, 1'b1);
      beat(1, 0, 1'b1);
      beat(1, 1, 1'b1);
      chk("table_valid", valid_out_pool, 1);
      chk("table_ch1", pool_out_1, tv[i].e);
      chk("table_ch2", pool_out_2, tv[i].e);
      chk("table_ch3", pool_out_3, tv[i].e);
    end
    do_reset();
    fill_ramp();
    npulse = 0;
    nfd = 0;
    run_frame(1'b0);
    check_ramp("ramp");
    npulse = 0;
    nfd = 0;
    run_frame(1'b1);
    check_ramp("gapped");
    for (int i = 0; i < 300; i++) beat(i / W, i % W, 1'b1);
    do_reset();
    npulse = 0;
    nfd = 0;
    run_frame(1'b0);
    check_ramp("midreset");
    fill_rand();
    npulse = 0;
    nfd = 0;
    run_frame(1'b0);
    fill_rand();
    run_frame(1'b0);
    chk("b2b_pulses", npulse, 288);
    chk("b2b_frame_done_count", nfd, 2);
    fill_rand();
    npulse = 0;
    nfd = 0;
    run_frame(1'b1);
    chk("rand_gap_pulses", npulse, 144);
    chk("rand_gap_frame_done_count", nfd, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maxpool1_layer.md
MAXPOOL1_LAYER -- requirements
Module: maxpool1_layer

Interface
REQ-001 SHALL have parameter WIDTH, default 24: conv feature-map columns; must be even.
REQ-002 SHALL have parameter HEIGHT, default 24: conv feature-map rows; must be even.
REQ-003 SHALL have parameter DATA_BITS, default 12: sample width, signed two's complement.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-high reset; asserted = 1, sampled on clk.
REQ-006 SHALL have ports conv_out_1, conv_out_2, conv_out_3, input, DATA_BITS each: channel samples from the conv1 stage, raster order.
REQ-007 SHALL have port valid_out_conv, input, 1: the three conv samples are valid this cycle.
REQ-008 SHALL have ports pool_out_1, pool_out_2, pool_out_3, output, DATA_BITS each: 2x2 max-pooled channel results.
REQ-009 SHALL have port valid_out_pool, output, 1: single-cycle pulse, pool outputs valid.
REQ-010 SHALL have port frame_done, output, 1: single-cycle pulse with the last pooled output of a frame.

Function
REQ-011 SHALL keep column counter col (0..WIDTH-1) and row counter row (0..HEIGHT-1), advancing only on valid_out_conv=1.
REQ-012 SHALL wrap col to 0 and increment row after col=WIDTH-1; SHALL wrap row to 0 after (HEIGHT-1, WIDTH-1), with no idle cycle needed between frames.
REQ-013 SHALL hold all counters and internal state in cycles with valid_out_conv=0; gaps of any length SHALL be allowed.
REQ-014 On even col, SHALL store each channel sample in a per-channel pair register.
REQ-015 On odd col, SHALL form hmax = signed max(pair register, current sample) per channel.
REQ-016 On even row and odd col, SHALL write hmax into a per-channel line buffer of WIDTH/2 entries at index col>>1. No output SHALL be produced.
REQ-017 On odd row and odd col, SHALL register signed max(linebuf[col>>1], hmax) to pool_out_n and assert valid_out_pool for exactly the next cycle. Latency is 1 clk from the qualifying input beat.
REQ-018 All comparisons SHALL be signed DATA_BITS-wide. On ties, the equal value is output. No saturation or width growth.
REQ-019 pool_out_n SHALL hold their last value while valid_out_pool=0.
REQ-020 SHALL produce exactly (WIDTH/2)*(HEIGHT/2) valid_out_pool pulses per frame (144 at defaults), in raster order of the pooled map.
REQ-021 SHALL assert frame_done in the same cycle as the valid_out_pool pulse for input beat (HEIGHT-1, WIDTH-1). It is 0 at all other times.
REQ-022 The block SHALL provide no backpressure. It SHALL accept one beat per cycle sustained.
REQ-023 When valid_out_conv is high in the same cycle an output is being registered, the block SHALL process both with no loss.

Reset
REQ-024 While rst_n=1 at a clk edge, SHALL clear col, row, pair registers, pool_out_1..3, valid_out_pool and frame_done to 0.
REQ-025 Line buffer contents need not be cleared, because every entry is written in an even row before it is read.
REQ-026 Reset mid-frame SHALL discard the partial frame. The first valid beat after reset is pixel (0,0). No output pulse SHALL come from pre-reset data.
REQ-027 An input beat presented while rst_n=1 SHALL be ignored.

Verification
REQ-028 Reset: hold rst_n=1 for 2 cycles with valid_out_conv=1 and random data -> all outputs 0, and no valid_out_pool pulse afterwards until a new odd-row/odd-col beat arrives.
REQ-029 Ramp frame: channel 1 = row*24+col, channels 2/3 = negated ramp, contiguous valid -> 144 pulses. First pool_out_1=25 and pool_out_2=-0 block max=0. Last pool_out_1=575 with frame_done=1.
REQ-030 Signed block: 2x2 values -5,-3 / -7,-1 on all channels -> pool_out=0xFFF (-1) one cycle after the (1,1) beat.
REQ-031 Gapped input: ramp frame with valid_out_conv randomly low 50% of cycles -> output sequence identical to REQ-029, with each pulse 1 cycle after its (odd,odd) beat.
REQ-032 Mid-frame reset: reset after input beat 300, then a full ramp frame -> exactly 144 pulses matching REQ-029, with one frame_done.
REQ-033 Back-to-back: two contiguous frames with different data, no idle cycle -> 288 pulses and 2 frame_done pulses; second-frame results are uncorrupted by first-frame line buffer contents.
